// File: rtl/led_refresh_scheduler_if.sv
// Bundle between the refresh requesters / LED controller and the scheduler.
// The master side drives requests and holds; the slave side (the scheduler)
// answers with the refresh pulse, lock, served mask and status.
interface led_refresh_scheduler_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] src_req;
  logic [NUM_SRC-1:0] src_hold;
  logic               refresh;
  logic               refresh_lock;
  logic [NUM_SRC-1:0] served;
  logic               busy;
  logic [15:0]        frame_count;

  modport master (
    output src_req, src_hold,
    input  refresh, refresh_lock, served, busy, frame_count
  );

  modport slave (
    input  src_req, src_hold,
    output refresh, refresh_lock, served, busy, frame_count
  );
endinterface

// File: rtl/led_refresh_scheduler.sv
// LED refresh scheduler: coalesces per-source refresh requests into frames,
// waits for the lock to drop before issuing, then blocks for the frame time
// plus the latch gap.
// Optional: define LED_SCHED_WATCHDOG_EN to add an AUTO_PERIOD auto-refresh.
// Refresh cadence: ISSUE(1) + SENDING(FRAME_CYCLES-1) + HOLDOFF(GAP_CYCLES)
// + IDLE(1) + WAIT_UNLOCK(1) = FRAME_CYCLES+GAP_CYCLES+2 cycles minimum; the
// ISSUE cycle is the first cycle of the frame shifting out.
module led_refresh_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int FRAME_CYCLES = 480000,
  parameter int GAP_CYCLES   = 4000,
  parameter int AUTO_PERIOD  = 1000000
) (
  input logic clk,
  input logic rst_n,
  led_refresh_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT_UNLOCK, ISSUE, SENDING, HOLDOFF} state_t;

  localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  // With a one-cycle frame the ISSUE cycle is the whole frame.
  localparam bit          HAS_SEND  = (FRAME_CYCLES > 1);
  localparam logic [CW-1:0] SEND_LAST = CW'((FRAME_CYCLES > 1) ? FRAME_CYCLES - 2 : 0);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [NUM_SRC-1:0] pending;
  logic               auto_pend;
  logic               go_issue;
  logic               want;

  // Issue decision and "something to refresh" condition.
  always_comb begin
    go_issue = (state == WAIT_UNLOCK) && !bus.refresh_lock;
    want     = (|pending) || (|bus.src_req) || auto_pend;
  end

  // Lock follows the OR of all holds one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.refresh_lock <= 1'b0;
    else        bus.refresh_lock <= |bus.src_hold;
  end

  // Main FSM with registered refresh/served/busy/frame_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      pending         <= '0;
      bus.refresh     <= 1'b0;
      bus.served      <= '0;
      bus.busy        <= 1'b0;
      bus.frame_count <= '0;
    end else begin
      bus.refresh <= 1'b0;
      bus.served  <= '0;
      // Snapshot clears all pending bits; a request sampled on the same edge
      // stays pending for the next frame.
      pending <= (go_issue ? '0 : pending) | bus.src_req;
      case (state)
        IDLE: begin
          if (want) begin
            state    <= WAIT_UNLOCK;
            bus.busy <= 1'b1;
          end
        end
        WAIT_UNLOCK: begin
          if (go_issue) begin
            state           <= ISSUE;
            bus.refresh     <= 1'b1;
            bus.served      <= pending;
            bus.frame_count <= bus.frame_count + 16'd1;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= HAS_SEND ? SENDING : HOLDOFF;
        end
        SENDING: begin
          if (cnt == SEND_LAST) begin
            cnt   <= '0;
            state <= HOLDOFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLDOFF: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef LED_SCHED_WATCHDOG_EN
  localparam int WD_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  // Flag is raised two cycles early so the IDLE->WAIT_UNLOCK->ISSUE path
  // lands the auto refresh exactly AUTO_PERIOD cycles after the last one.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((AUTO_PERIOD >= 2) ? AUTO_PERIOD - 2 : 0);

  logic [WD_W-1:0] wd_cnt;

  // Saturating watchdog, restarted by every issued frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wd_cnt <= '0;
    else if (go_issue)          wd_cnt <= '0;
    else if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + 1'b1;
  end

  assign auto_pend = (wd_cnt == WD_LAST);
`else
  assign auto_pend = 1'b0;
`endif

endmodule

// File: tb/tb_led_refresh_scheduler.sv
// Scoreboard bench for led_refresh_scheduler: each scenario pushes the served
// mask it expects; the negedge monitor pops one entry per refresh pulse.
module tb_led_refresh_scheduler;
  localparam int NS      = 4;
  localparam int FC      = 20;
  localparam int GC      = 5;
  localparam int AP      = 100;
  localparam int SPACING = FC + GC + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_refresh_scheduler_if #(.NUM_SRC(NS)) bus();

  led_refresh_scheduler #(
    .NUM_SRC(NS), .FRAME_CYCLES(FC), .GAP_CYCLES(GC), .AUTO_PERIOD(AP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ref    = 0;
  int last_ref_cyc = 0;
  int prev_ref_cyc = 0;
  logic [15:0]   exp_fc = '0;
  logic [NS-1:0] exp_q[$];
  logic [NS-1:0] exp_m;

  always @(posedge clk) cyc++;

  // Monitor: every refresh pops one expected served mask.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.refresh === 1'b1) begin
        prev_ref_cyc = last_ref_cyc;
        last_ref_cyc = cyc;
        n_ref++;
        exp_fc++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_refresh: served=%b at cycle %0d, required no refresh", bus.served, cyc);
        end else begin
          exp_m = exp_q.pop_front();
          if (bus.served !== exp_m) begin
            n_fail++;
            $display("FAIL served: got %b, required %b (cycle %0d)", bus.served, exp_m, cyc);
          end
        end
        n_checks++;
        if (bus.frame_count !== exp_fc) begin
          n_fail++;
          $display("FAIL frame_count: got %0d, required %0d", bus.frame_count, exp_fc);
        end
      end else begin
        n_checks++;
        if (bus.served !== '0) begin
          n_fail++;
          $display("FAIL served_idle: got %b, required 0 (cycle %0d)", bus.served, cyc);
        end
      end
    end
  end

  task automatic pulse(input logic [NS-1:0] m);
    bus.src_req = m;
    @(negedge clk);
    bus.src_req = '0;
  endtask

  task automatic wait_ref(input int target, input int limit);
    int t = 0;
    while (n_ref < target && t < limit) begin
      @(negedge clk); #1;
      t++;
    end
    n_checks++;
    if (n_ref < target) begin
      n_fail++;
      $display("FAIL refresh_timeout: got %0d refreshes, required %0d", n_ref, target);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.src_req  = '0;
    bus.src_hold = '0;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (bus.refresh !== 1'b0)      begin n_fail++; $display("FAIL rst_refresh: got %b, required 0", bus.refresh); end
    if (bus.served !== '0)         begin n_fail++; $display("FAIL rst_served: got %b, required 0", bus.served); end
    if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    if (bus.refresh_lock !== 1'b0) begin n_fail++; $display("FAIL rst_lock: got %b, required 0", bus.refresh_lock); end
    if (bus.frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_fc: got %0d, required 0", bus.frame_count); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int base = n_ref;
    int t0;
    exp_q.push_back(4'b0001);
    t0 = cyc;
    pulse(4'b0001);
    wait_ref(base + 1, 100);
    n_checks++;
    if (last_ref_cyc !== t0 + 2) begin
      n_fail++;
      $display("FAIL single_latency: refresh at cycle %0d, required %0d", last_ref_cyc, t0 + 2);
    end
    n_checks++;
    if (bus.frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_fc: got %0d, required 1", bus.frame_count);
    end
    wait_idle();
  endtask

  task automatic test_lock();
    int base = n_ref;
    int h;
    @(negedge clk);
    exp_q.push_back(4'b0001);
    bus.src_hold = 4'b0100;
    pulse(4'b0001);
    repeat (49) @(negedge clk);
    n_checks += 3;
    if (bus.refresh_lock !== 1'b1) begin n_fail++; $display("FAIL lock_high: got %b, required 1", bus.refresh_lock); end
    if (bus.busy !== 1'b1)         begin n_fail++; $display("FAIL lock_busy: got %b, required 1", bus.busy); end
    if (n_ref !== base)            begin n_fail++; $display("FAIL lock_early: got %0d refreshes, required %0d", n_ref, base); end
    h = cyc;
    bus.src_hold = '0;
    wait_ref(base + 1, 100);
    n_checks++;
    if (last_ref_cyc !== h + 2) begin
      n_fail++;
      $display("FAIL lock_release: refresh at cycle %0d, required %0d", last_ref_cyc, h + 2);
    end
    wait_idle();
  endtask

  task automatic test_coalesce();
    int base = n_ref;
    int r1;
    @(negedge clk);
    exp_q.push_back(4'b0001);
    pulse(4'b0001);
    wait_ref(base + 1, 100);
    r1 = last_ref_cyc;
    repeat (3) @(negedge clk);
    exp_q.push_back(4'b1010);
    pulse(4'b0010);
    repeat (3) @(negedge clk);
    pulse(4'b1000);
    wait_ref(base + 2, 200);
    n_checks++;
    if (last_ref_cyc - r1 !== SPACING) begin
      n_fail++;
      $display("FAIL coalesce_spacing: got %0d, required %0d", last_ref_cyc - r1, SPACING);
    end
    wait_idle();
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_ref !== base + 2) begin
      n_fail++;
      $display("FAIL coalesce_count: got %0d refreshes, required %0d", n_ref - base, 2);
    end
  endtask

  task automatic test_race();
    int base = n_ref;
    int t0;
    @(negedge clk);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    t0 = cyc;
    bus.src_req = 4'b0001;
    @(negedge clk);
    bus.src_req = '0;
    @(negedge clk);
    bus.src_req = 4'b0100;   // lands in the ISSUE cycle
    @(negedge clk);
    bus.src_req = '0;
    wait_ref(base + 2, 200);
    n_checks += 2;
    if (prev_ref_cyc !== t0 + 2) begin
      n_fail++;
      $display("FAIL race_first: refresh at cycle %0d, required %0d", prev_ref_cyc, t0 + 2);
    end
    if (last_ref_cyc - prev_ref_cyc !== SPACING) begin
      n_fail++;
      $display("FAIL race_spacing: got %0d, required %0d", last_ref_cyc - prev_ref_cyc, SPACING);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int base = n_ref;
    @(negedge clk);
    exp_q.push_back(4'b1000);
    pulse(4'b1000);
    wait_ref(base + 1, 100);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_fc = '0;
    n_checks += 3;
    if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", bus.busy); end
    if (bus.frame_count !== 16'd0) begin n_fail++; $display("FAIL midrst_fc: got %0d, required 0", bus.frame_count); end
    if (bus.refresh !== 1'b0)      begin n_fail++; $display("FAIL midrst_refresh: got %b, required 0", bus.refresh); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    n_checks += 3;
    if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL postrst_busy: got %b, required 0", bus.busy); end
    if (bus.frame_count !== 16'd0) begin n_fail++; $display("FAIL postrst_fc: got %0d, required 0", bus.frame_count); end
    if (n_ref !== base + 1)        begin n_fail++; $display("FAIL postrst_refresh: got %0d refreshes, required %0d", n_ref - base, 1); end
  endtask

  task automatic test_quiet();
    int base = n_ref;
    repeat (300) @(negedge clk);
    n_checks += 2;
    if (n_ref !== base)    begin n_fail++; $display("FAIL quiet_refresh: got %0d refreshes, required 0", n_ref - base); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL quiet_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_watchdog();
    int base = n_ref;
    int r;
    int period;
    period = (AP > SPACING) ? AP : SPACING;
    repeat (3) exp_q.push_back('0);
    wait_ref(base + 1, 1000);
    r = last_ref_cyc;
    wait_ref(base + 2, 1000);
    n_checks++;
    if (last_ref_cyc - r !== period) begin
      n_fail++;
      $display("FAIL wd_period1: got %0d, required %0d", last_ref_cyc - r, period);
    end
    r = last_ref_cyc;
    wait_ref(base + 3, 1000);
    n_checks++;
    if (last_ref_cyc - r !== period) begin
      n_fail++;
      $display("FAIL wd_period2: got %0d, required %0d", last_ref_cyc - r, period);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
`ifdef LED_SCHED_WATCHDOG_EN
    test_watchdog();
`else
    test_single();
    test_lock();
    test_coalesce();
    test_race();
    test_reset_mid();
    test_quiet();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_refresh_scheduler.md
LED_REFRESH_SCHEDULER -- requirements
Module: led_refresh_scheduler

Interface
REQ-001 Parameter NUM_SRC, default 4: number of refresh requesters.
REQ-002 Parameter FRAME_CYCLES, default 480000: clk cycles one full LED frame takes to shift out.
REQ-003 Parameter GAP_CYCLES, default 4000: minimum idle clk cycles between frames (LED latch gap).
REQ-004 Parameter AUTO_PERIOD, default 1000000: watchdog auto-refresh interval in clk cycles.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 src_req  input  NUM_SRC  per-source refresh request, level or one-cycle pulse.
REQ-008 src_hold  input  NUM_SRC  per-source "cell data being updated, do not snapshot".
REQ-009 refresh  output  1  one-cycle pulse to LED controller requesting a frame.
REQ-010 refresh_lock  output  1  registered OR of src_hold, drives LED controller lock.
REQ-011 served  output  NUM_SRC  one-cycle mask of sources whose requests the issued frame covers.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_count  output  16  number of refresh pulses issued, wraps modulo 2^16.

Function
REQ-014 States: IDLE, WAIT_UNLOCK, ISSUE, SENDING, HOLDOFF; encoding free.
REQ-015 pending[NUM_SRC] sets on any src_req bit high; cleared only by a served pulse for that bit.
REQ-016 IDLE -> WAIT_UNLOCK when any pending bit is set (or src_req high in the same cycle).
REQ-017 WAIT_UNLOCK -> ISSUE on the first cycle refresh_lock is low; otherwise stays.
REQ-018 ISSUE lasts exactly one cycle: refresh=1, served=pending snapshot, those pending bits cleared, frame_count+1.
REQ-019 A src_req bit arriving during the ISSUE cycle is not in served; it remains pending for the next frame.
REQ-020 SENDING counts FRAME_CYCLES cycles then -> HOLDOFF; HOLDOFF counts GAP_CYCLES cycles then -> IDLE.
REQ-021 Requests during SENDING/HOLDOFF accumulate in pending; multiple requests coalesce into one frame.
REQ-022 Latency: request in IDLE with lock low -> refresh pulse exactly 2 cycles after src_req sampled.
REQ-023 Minimum refresh-to-refresh spacing is FRAME_CYCLES+GAP_CYCLES+2 cycles.
REQ-024 refresh_lock is registered: follows src_hold OR with 1-cycle latency.
REQ-025 Counters sized by $clog2 of their parameter; no overflow for any legal parameter value (>=1).
REQ-026 refresh and served are zero in every state except ISSUE.

Reset
REQ-027 rst_n low asynchronously forces IDLE; pending, counters, frame_count cleared.
REQ-028 During reset refresh=0, served=0, busy=0, refresh_lock=0, frame_count=0.
REQ-029 Reset mid-SENDING abandons the frame; no refresh is reissued after release unless newly requested.

Configuration
REQ-030 Macro LED_SCHED_WATCHDOG_EN defined: an AUTO_PERIOD counter, reset by every ISSUE, sets an internal auto-pending flag on expiry, treated as a request with served all-zero if no source pending.
REQ-031 LED_SCHED_WATCHDOG_EN undefined: no watchdog counter exists; frames issue only on src_req.

Verification
REQ-032 Single req: src_req=4'b0001 pulse in IDLE, hold=0 -> refresh 2 cycles later, served=4'b0001, frame_count=1.
REQ-033 Lock: src_hold[2]=1 for 50 cycles with src_req[0] pulse -> refresh pulse not before cycle after refresh_lock falls.
REQ-034 Coalesce: pulses on src_req[1] and src_req[3] during SENDING -> exactly one next refresh with served=4'b1010, spaced FRAME_CYCLES+GAP_CYCLES+2 from previous.
REQ-035 Race: src_req[2] pulse coincident with ISSUE -> served excludes bit 2; second frame serves 4'b0100.
REQ-036 Reset: rst_n low mid-SENDING, then high, no requests -> no refresh, busy=0, frame_count=0.
REQ-037 Watchdog (macro on, AUTO_PERIOD=100): no requests -> refresh every max(100, FRAME_CYCLES+GAP_CYCLES+2) cycles, served=0.
